// File: rtl/jk_bank_arb.sv
// Purpose : bank of WIDTH JK bits; a two-requester round-robin arbiter picks one
//           command, which is then applied to one addressed bit for cnt edges.
// Latency : gnt one cycle after accept; busy for N cycles; done the cycle after the
//           last application; back-to-back throughput is N+1 cycles per command.
// Backpr. : requests are looked at only while idle; a requester keeps req high
//           until it sees its gnt pulse and must drop it during that gnt cycle.
//
// Ports   : clk, clr (async, active-high)
//           req_a/b, addr_a/b, j_a/b, k_a/b, cnt_a/b (0 = 16)  command inputs
//           gnt_a/b   one-cycle accept pulses
//           busy      command in progress; done/done_id completion pulse and owner
//           q         bank state, registered only
// Option  : define JK_ARB_PRE_EN to add a synchronous 'pre' input that sets all of
//           q to 1 and aborts any active command (clr still takes precedence).
module jk_bank_arb #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr,
`ifdef JK_ARB_PRE_EN
    input  logic              pre,
`endif
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              j_a,
    input  logic              k_a,
    input  logic [3:0]        cnt_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              j_b,
    input  logic              k_b,
    input  logic [3:0]        cnt_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [WIDTH-1:0]  q
);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t            state, state_nxt;
    logic              prio, prio_nxt;        // 0 = A has priority on collision
    logic              own, own_nxt;          // 0 = A owns the running command
    logic [ADDR_W-1:0] addr_r, addr_nxt;
    logic              j_r, j_nxt;
    logic              k_r, k_nxt;
    logic [4:0]        rem, rem_nxt;          // holds 1..16
    logic              gnt_a_nxt, gnt_b_nxt;
    logic              done_nxt, done_id_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              pick_b;

    assign busy = (state == APPLY);

    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio;
        own_nxt     = own;
        addr_nxt    = addr_r;
        j_nxt       = j_r;
        k_nxt       = k_r;
        rem_nxt     = rem;
        gnt_a_nxt   = 1'b0;
        gnt_b_nxt   = 1'b0;
        done_nxt    = 1'b0;
        done_id_nxt = 1'b0;
        q_nxt       = q;
        // B wins when it is the only requester, or on a collision when prio names B
        pick_b      = req_b & (~req_a | prio);

        case (state)
            IDLE: begin
                if (req_a | req_b) begin
                    own_nxt   = pick_b;
                    addr_nxt  = pick_b ? addr_b : addr_a;
                    j_nxt     = pick_b ? j_b : j_a;
                    k_nxt     = pick_b ? k_b : k_a;
                    rem_nxt   = (pick_b ? cnt_b : cnt_a) == 4'd0 ? 5'd16
                                : {1'b0, (pick_b ? cnt_b : cnt_a)};
                    gnt_a_nxt = ~pick_b;
                    gnt_b_nxt = pick_b;
                    prio_nxt  = ~pick_b;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                // An out-of-range address matches no bit, so the command still
                // times out normally but leaves the bank untouched.
                for (int i = 0; i < WIDTH; i++) begin
                    if (addr_r == ADDR_W'(i)) begin
                        case ({j_r, k_r})
                            2'b01:   q_nxt[i] = 1'b0;
                            2'b10:   q_nxt[i] = 1'b1;
                            2'b11:   q_nxt[i] = ~q[i];
                            default: q_nxt[i] = q[i];
                        endcase
                    end
                end
                rem_nxt = rem - 5'd1;
                if (rem == 5'd1) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    done_id_nxt = own;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef JK_ARB_PRE_EN
        // Preset wins over everything except clr: no grant, no done, no arbitration.
        if (pre) begin
            q_nxt       = '1;
            state_nxt   = IDLE;
            rem_nxt     = 5'd0;
            prio_nxt    = prio;
            own_nxt     = own;
            addr_nxt    = addr_r;
            j_nxt       = j_r;
            k_nxt       = k_r;
            gnt_a_nxt   = 1'b0;
            gnt_b_nxt   = 1'b0;
            done_nxt    = 1'b0;
            done_id_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            prio    <= 1'b0;
            own     <= 1'b0;
            addr_r  <= '0;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            rem     <= 5'd0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            q       <= '0;
        end else begin
            state   <= state_nxt;
            prio    <= prio_nxt;
            own     <= own_nxt;
            addr_r  <= addr_nxt;
            j_r     <= j_nxt;
            k_r     <= k_nxt;
            rem     <= rem_nxt;
            gnt_a   <= gnt_a_nxt;
            gnt_b   <= gnt_b_nxt;
            done    <= done_nxt;
            done_id <= done_id_nxt;
            q       <= q_nxt;
        end
    end

endmodule

// File: tb/tb_jk_bank_arb.sv
// Purpose : self-checking bench for jk_bank_arb against a transaction-level model.
// Latency : model predicts gnt/busy/done/q per edge from the command schedule.
// Backpr. : requesters hold req until their gnt pulse, then drop it.
module tb_jk_bank_arb;

    localparam int W  = 6;   // narrower than 2**AW so out-of-range addresses exist
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          clr;
`ifdef JK_ARB_PRE_EN
    logic          pre;
`endif
    logic          req_a, req_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          j_a, k_a, j_b, k_b;
    logic [3:0]    cnt_a, cnt_b;
    logic          gnt_a, gnt_b, busy, done, done_id;
    logic [W-1:0]  q;

    jk_bank_arb #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .clr(clr),
`ifdef JK_ARB_PRE_EN
        .pre(pre),
`endif
        .req_a(req_a), .addr_a(addr_a), .j_a(j_a), .k_a(k_a), .cnt_a(cnt_a),
        .req_b(req_b), .addr_b(addr_b), .j_b(j_b), .k_b(k_b), .cnt_b(cnt_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .done(done),
        .done_id(done_id), .q(q)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: a command is a scheduled window of edges.
    logic [W-1:0] m_q;
    bit           m_active;
    int           edge_n = 0;
    int           m_end;
    bit           m_prio;     // 1 = B wins the next collision
    bit           m_own;
    int           m_addr;
    bit           m_j, m_k;
    bit           e_ga, e_gb, e_done, e_did;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit jk(input bit cur, input bit j, input bit k);
        if (j && k) return !cur;
        if (j)      return 1'b1;
        if (k)      return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        m_q = '0; m_active = 0; m_prio = 0; m_own = 0;
        e_ga = 0; e_gb = 0; e_done = 0; e_did = 0;
    endtask

    task automatic model_step();
        bit win_b;
        int n;
        edge_n++;
        e_ga = 0; e_gb = 0; e_done = 0; e_did = 0;
`ifdef JK_ARB_PRE_EN
        if (pre) begin
            m_q = '1;
            m_active = 0;
            return;
        end
`endif
        if (m_active) begin
            if (m_addr < W) m_q[m_addr] = jk(m_q[m_addr], m_j, m_k);
            if (edge_n == m_end) begin
                m_active = 0;
                e_done = 1;
                e_did = m_own;
            end
        end else if (req_a || req_b) begin
            win_b  = (req_a && req_b) ? m_prio : req_b;
            m_own  = win_b;
            m_addr = win_b ? int'(addr_b) : int'(addr_a);
            m_j    = win_b ? j_b : j_a;
            m_k    = win_b ? k_b : k_a;
            n      = win_b ? int'(cnt_b) : int'(cnt_a);
            if (n == 0) n = 16;
            m_end  = edge_n + n;
            m_active = 1;
            e_ga   = !win_b;
            e_gb   = win_b;
            m_prio = !win_b;
        end
    endtask

    task automatic compare_all();
        check("q", q, m_q);
        check("busy", busy, m_active);
        check("gnt_a", gnt_a, e_ga);
        check("gnt_b", gnt_b, e_gb);
        check("done", done, e_done);
        check("done_id", done_id, e_did);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called just after a negedge: clr rises and falls between clock edges.
    task automatic pulse_clr();
        req_a = 0; req_b = 0;
        #2 clr = 1;
        #1;
        model_reset();
        check("clr_q", q, 0);
        check("clr_busy", busy, 0);
        check("clr_gnt", {gnt_a, gnt_b}, 0);
        compare_all();
        #1 clr = 0;
    endtask

    task automatic rand_a();
        addr_a = AW'($urandom_range(0, 7));
        j_a = 1'($urandom_range(0, 1)); k_a = 1'($urandom_range(0, 1));
        cnt_a = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_b();
        addr_b = AW'($urandom_range(0, 7));
        j_b = 1'($urandom_range(0, 1)); k_b = 1'($urandom_range(0, 1));
        cnt_b = 4'($urandom_range(0, 15));
    endtask

    initial begin
        clr = 0; req_a = 0; req_b = 0;
        addr_a = '0; addr_b = '0; j_a = 0; k_a = 0; j_b = 0; k_b = 0;
        cnt_a = '0; cnt_b = '0;
`ifdef JK_ARB_PRE_EN
        pre = 0;
`endif
        model_reset();
        @(negedge clk);
        pulse_clr();

        // Set bit 2 once from q = 0
        addr_a = 2; j_a = 1; k_a = 0; cnt_a = 1; req_a = 1;
        cycle();
        check("set_gnt_a", gnt_a, 1);
        req_a = 0;
        cycle();
        check("set_q", q, 6'h04);
        check("set_done", done, 1);
        check("set_done_id", done_id, 0);

        // Toggle bit 0 three times
        addr_b = 0; j_b = 1; k_b = 1; cnt_b = 3; req_b = 1;
        cycle();
        check("tog_gnt_b", gnt_b, 1);
        req_b = 0;
        cycle(); check("tog_q1", q, 6'h05);
        cycle(); check("tog_q2", q, 6'h04);
        cycle(); check("tog_q3", q, 6'h05);
        check("tog_done", done, 1);
        check("tog_done_id", done_id, 1);

        // cnt = 0 means 16 toggles: bit 0 ends where it started
        cnt_b = 0; req_b = 1;
        cycle();
        req_b = 0;
        repeat (15) cycle();
        check("cnt16_busy", busy, 1);
        cycle();
        check("cnt16_q", q, 6'h05);
        check("cnt16_done", done, 1);

        // Address beyond the bank: timed normally, no bit changes
        addr_a = 7; j_a = 1; k_a = 1; cnt_a = 2; req_a = 1;
        cycle();
        req_a = 0;
        cycle(); cycle();
        check("oor_q", q, 6'h05);
        check("oor_done", done, 1);

        // Collision after reset: A first, then B wins the repeated collision
        pulse_clr();
        addr_a = 3; j_a = 1; k_a = 0; cnt_a = 2;
        addr_b = 4; j_b = 1; k_b = 0; cnt_b = 1;
        req_a = 1; req_b = 1;
        cycle();
        check("col1_gnt_a", gnt_a, 1);
        check("col1_gnt_b", gnt_b, 0);
        req_a = 0;
        cycle();
        req_a = 1;
        cycle();
        cycle();
        check("col2_gnt_b", gnt_b, 1);
        check("col2_gnt_a", gnt_a, 0);
        check("col2_q", q, 6'h08);
        req_b = 0;
        cycle();
        cycle();
        check("col3_gnt_a", gnt_a, 1);
        req_a = 0;
        cycle(); cycle();
        check("col3_q", q, 6'h18);

        // Reset during a command: no done, bank cleared
        addr_a = 1; j_a = 1; k_a = 1; cnt_a = 5; req_a = 1;
        cycle();
        req_a = 0;
        cycle(); cycle();
        check("mid_busy", busy, 1);
        pulse_clr();
        cycle();
        check("mid_done", done, 0);
        check("mid_idle", busy, 0);

`ifdef JK_ARB_PRE_EN
        addr_a = 0; j_a = 1; k_a = 1; cnt_a = 4; req_a = 1;
        cycle();
        req_a = 0;
        cycle();
        pre = 1;
        cycle();
        pre = 0;
        check("pre_q", q, 6'h3F);
        check("pre_busy", busy, 0);
        check("pre_done", done, 0);
        repeat (3) cycle();
`endif

        // Randomized traffic
        rand_a(); rand_b();
        repeat (2500) begin
            if (gnt_a) begin req_a = 0; rand_a(); end
            else if (!req_a && $urandom_range(0, 3) == 0) begin rand_a(); req_a = 1; end
            if (gnt_b) begin req_b = 0; rand_b(); end
            else if (!req_b && $urandom_range(0, 3) == 0) begin rand_b(); req_b = 1; end
`ifdef JK_ARB_PRE_EN
            pre = ($urandom_range(0, 149) == 0);
`endif
            if ($urandom_range(0, 299) == 0) pulse_clr();
            cycle();
        end
        req_a = 0; req_b = 0;
`ifdef JK_ARB_PRE_EN
        pre = 0;
`endif
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
